window_serializer: RTL and testbench

Read-side counterpart of the `shift_reg2` pixel window in the convolution datapath. It captures the full N-tap window (`dout[N-1:0]` of `shift_reg2`) in one parallel load, then streams the taps out one per beat over a valid/ready interface for the downstream MAC / DMA stage. Stream order is ascending or descending tap index, selected per window, to mirror the register's upward/downward shift modes.

---
 rtl/window_serializer_if.sv | 35 +++
 rtl/window_serializer.sv | 108 ++++++++++
 tb/tb_window_serializer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/window_serializer_if.sv
// window_serializer_if
//   Handshake bundle between a window producer/consumer and window_serializer.
//   Parameters N (taps per window) and B (bits per tap) must match the DUT.
//
//   Load side : load, dir, win[N-1:0] (producer -> DUT); load_ready (DUT -> producer)
//   Beat side : dout, dout_valid, dout_last (DUT -> consumer); dout_ready (consumer -> DUT)
//   Status    : busy (window in flight), state_dbg (raw FSM state, 0=IDLE 1=SEND)
//
//   master : the environment side (drives load/dir/win/dout_ready)
//   slave  : the serializer side
interface window_serializer_if #(
   parameter int N = 11,
   parameter int B = 8
);
   logic         load;
   logic         dir;
   logic [B-1:0] win [N-1:0];
   logic         load_ready;
   logic [B-1:0] dout;
   logic         dout_valid;
   logic         dout_ready;
   logic         dout_last;
   logic         busy;
   logic         state_dbg;

   modport master (
      output load, dir, win, dout_ready,
      input  load_ready, dout, dout_valid, dout_last, busy, state_dbg
   );

   modport slave (
      input  load, dir, win, dout_ready,
      output load_ready, dout, dout_valid, dout_last, busy, state_dbg
   );
endinterface

// File: rtl/window_serializer.sv
// window_serializer
//   Captures an N-tap pixel window in one parallel load and streams the taps
//   out one per beat, ascending (dir=0, tap 0 first) or descending (dir=1,
//   tap N-1 first).
//
//   Ports:
//     clk   - system clock, rising edge
//     rstn  - asynchronous active-low reset
//     bus   - window_serializer_if.slave: load/dir/win/load_ready capture
//             handshake, dout/dout_valid/dout_ready/dout_last beat stream,
//             busy and state_dbg status
//
//   Handshake semantics (both channels): a transfer happens at a rising edge
//   where valid and ready are both high. Load channel: valid=load,
//   ready=load_ready. Beat channel: valid=dout_valid, ready=dout_ready. Once
//   dout_valid rises it stays high with dout/dout_last stable until the beat
//   is taken; it only falls after the last beat (or on reset).
module window_serializer #(
   parameter int N = 11,
   parameter int B = 8
) (
   input  logic           clk,
   input  logic           rstn,
   window_serializer_if.slave bus
);

   localparam int            IW   = $clog2(N);
   localparam logic [IW-1:0] LAST = IW'(N - 1);
   localparam logic [IW-1:0] ONE  = IW'(1);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [B-1:0]  buf_q [N];
   logic [IW-1:0] idx_q, idx_d;
   logic [IW-1:0] cnt_q, cnt_d;
   logic          dir_q, dir_d;

   logic          is_last;
   logic          do_beat;
   logic          do_load;
   logic          load_ready;

   assign is_last = (state_q == SEND) && (cnt_q == LAST);
   assign do_beat = (state_q == SEND) && bus.dout_ready;

   // Accepting a new window on the last-beat edge gives zero-bubble
   // back-to-back windows; this is the one dout_ready -> load_ready path.
   assign load_ready = rstn && ((state_q == IDLE) || (do_beat && is_last));
   assign do_load    = bus.load && load_ready;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;

      if (do_beat) begin
         if (is_last) begin
            state_d = IDLE;
         end else begin
            idx_d = dir_q ? (idx_q - ONE) : (idx_q + ONE);
            cnt_d = cnt_q + ONE;
         end
      end

      // A load overrides the last-beat return to IDLE.
      if (do_load) begin
         state_d = SEND;
         dir_d   = bus.dir;
         idx_d   = bus.dir ? LAST : '0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < N; i++) buf_q[i] <= '0;
      end else if (do_load) begin
         for (int i = 0; i < N; i++) buf_q[i] <= bus.win[i];
      end
   end

   assign bus.dout       = buf_q[idx_q];
   assign bus.dout_valid = (state_q == SEND);
   assign bus.busy       = (state_q == SEND);
   assign bus.dout_last  = is_last;
   assign bus.load_ready = load_ready;
   assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_window_serializer.sv
// tb_window_serializer
//   Directed bench for window_serializer (N=11, B=8). Stimulus tasks push the
//   expected {last, tap} beats into exp_q when a window is loaded; an
//   independent negedge monitor compares every presented beat (stalled or
//   not) against the head of the queue and pops it when dout_ready is high.
module tb_window_serializer;

   localparam int N = 11;
   localparam int B = 8;
   localparam int W = B + 1;

   logic clk;
   logic rstn;

   window_serializer_if #(.N(N), .B(B)) bus ();

   window_serializer #(.N(N), .B(B)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [W-1:0] exp_q [$];
   int           checks = 0;
   int           errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [W-1:0] head;
      if (rstn && bus.dout_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: got dout=%0d last=%0b, required no beat (t=%0t)",
                     bus.dout, bus.dout_last, $time);
         end else begin
            head = exp_q[0];
            if ({bus.dout_last, bus.dout} !== head) begin
               errors++;
               $display("FAIL beat: got dout=%0d last=%0b, required dout=%0d last=%0b (t=%0t)",
                        bus.dout, bus.dout_last, head[B-1:0], head[B], $time);
            end
            if (bus.dout_ready) void'(exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_win(input int base, input int step);
      for (int i = 0; i < N; i++) bus.win[i] = B'(base + step * i);
   endtask

   task automatic push_exp(input logic d, input int base, input int step);
      logic [B-1:0] v;
      int           tap;
      for (int j = 0; j < N; j++) begin
         tap = d ? (N - 1 - j) : j;
         v   = B'(base + step * tap);
         exp_q.push_back({(j == N - 1), v});
      end
   endtask

   // Call just after a rising edge while the DUT is idle; returns in the
   // first cycle after the load edge (beat 1 on the bus).
   task automatic start_load(input logic d, input int base, input int step);
      set_win(base, step);
      bus.dir  = d;
      bus.load = 1'b1;
      push_exp(d, base, step);
      tick();
      bus.load = 1'b0;
   endtask

   task automatic stream_full(input logic d, input int base, input int step);
      bus.dout_ready = 1'b1;
      start_load(d, base, step);
      @(negedge clk);
      check("first_beat_valid", bus.dout_valid, 1);
      check("first_beat_busy", bus.busy, 1);
      repeat (10) tick();                       // cycle 11: last beat
      check("pending_before_last", exp_q.size(), 1);
      check("last_flag_on_beat11", bus.dout_last, 1);
      tick();                                   // cycle 12
      check("valid_after_window", bus.dout_valid, 0);
      check("busy_after_window", bus.busy, 0);
      check("queue_drained", exp_q.size(), 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rstn           = 1'b0;
      bus.load       = 1'b0;
      bus.dir        = 1'b0;
      bus.dout_ready = 1'b0;
      set_win(0, 0);

      // Reset and idle
      repeat (2) begin
         @(negedge clk);
         check("rst_load_ready", bus.load_ready, 0);
         check("rst_dout_valid", bus.dout_valid, 0);
         check("rst_busy", bus.busy, 0);
         check("rst_dout", bus.dout, 0);
         check("rst_dout_last", bus.dout_last, 0);
      end
      tick();
      rstn = 1'b1;
      @(negedge clk);
      check("post_rst_load_ready", bus.load_ready, 1);
      check("post_rst_dout_valid", bus.dout_valid, 0);
      check("post_rst_state", bus.state_dbg, 0);
      tick();

      // Ascending then descending, win[i] = 3 + 13*i
      stream_full(1'b0, 3, 13);
      stream_full(1'b1, 3, 13);

      // Backpressure: ready 1,0,1,0... -> 11 beats over 21 cycles
      bus.dout_ready = 1'b1;
      start_load(1'b0, 3, 13);
      for (int c = 1; c <= 21; c++) begin
         bus.dout_ready = (c % 2 == 1);
         if (c == 21) begin
            check("bp_pending_at_21", exp_q.size(), 1);
            check("bp_last_at_21", bus.dout_last, 1);
         end
         tick();
      end
      check("bp_valid_after", bus.dout_valid, 0);
      check("bp_queue_drained", exp_q.size(), 0);

      // Ignored load mid-window, then overlapped load on the last beat
      bus.dout_ready = 1'b1;
      start_load(1'b0, 3, 13);                  // cycle 1
      repeat (4) tick();                        // cycle 5
      set_win(200, 1);
      bus.dir  = 1'b1;
      bus.load = 1'b1;
      @(negedge clk);
      check("midload_not_ready", bus.load_ready, 0);
      tick();                                   // cycle 6
      bus.load = 1'b0;
      repeat (5) tick();                        // cycle 11: last beat
      set_win(100, 1);
      bus.dir  = 1'b1;
      bus.load = 1'b1;
      push_exp(1'b1, 100, 1);
      @(negedge clk);
      check("b2b_load_ready_on_last", bus.load_ready, 1);
      check("b2b_last_flag", bus.dout_last, 1);
      tick();                                   // new window, cycle 1
      bus.load = 1'b0;
      @(negedge clk);
      check("b2b_no_gap_valid", bus.dout_valid, 1);
      check("b2b_busy_held", bus.busy, 1);
      check("b2b_first_tap", bus.dout, 110);
      repeat (10) tick();                       // cycle 11 of new window
      check("b2b_last_flag2", bus.dout_last, 1);
      tick();
      check("b2b_valid_after", bus.dout_valid, 0);
      check("b2b_queue_drained", exp_q.size(), 0);

      // Mid-stream reset after 4 beats
      bus.dout_ready = 1'b1;
      start_load(1'b0, 3, 13);                  // cycle 1
      repeat (4) tick();                        // cycle 5: 4 beats taken
      check("mid_rst_pending", exp_q.size(), 7);
      rstn = 1'b0;
      #1;
      check("mid_rst_valid", bus.dout_valid, 0);
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_dout", bus.dout, 0);
      check("mid_rst_load_ready", bus.load_ready, 0);
      exp_q.delete();
      repeat (2) tick();
      rstn = 1'b1;
      stream_full(1'b0, 3, 13);

      check("final_queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
